// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer.
//   DEFAULT_DATA_W   : default width of instruction word, PC and address.
//   DEFAULT_RESET_PC : default PC value after reset.
//   state_t          : fetch FSM state encoding.
package fetch_sequencer_pkg;

    localparam int               DEFAULT_DATA_W   = 16;
    localparam logic [15:0]      DEFAULT_RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_LOAD  = 2'b10,
        ST_HOLD  = 2'b11
    } state_t;

endpackage

// File: rtl/fetch_sequencer_pc_counter.sv
// Program counter for the fetch sequencer (the pc_counter block).
// Ports:
//   clk, reset  : clock and synchronous active-high reset (count <= RESET_PC)
//   load        : replace count with load_value (wins over incr)
//   load_value  : branch target
//   incr        : count <= count + 1, wrapping at the top of the range
//   count       : current PC
//   count_next  : value count will take at the next edge (when not in reset)
module fetch_sequencer_pc_counter
    import fetch_sequencer_pkg::*;
#(
    parameter int                DATA_W   = DEFAULT_DATA_W,
    parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_value,
    input  logic              incr,
    output logic [DATA_W-1:0] count,
    output logic [DATA_W-1:0] count_next
);

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_next = count;
        if (load) begin
            count_next = load_value;
        end else if (incr) begin
            count_next = count + DATA_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= RESET_PC;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction fetch stage feeding the 16-bit instruction register.
// Owns the PC, issues word reads over a req/ack handshake and pulses ir_load
// for one cycle per fetched word.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   run, stall                  : level controls (enable fetching / hold issue)
//   branch_taken, branch_target : one-cycle redirect strobe and its target
//   mem_req, mem_addr           : read request and its (latched) address
//   mem_ack, mem_rdata          : read completion and returned word
//   ir_in, ir_load              : word and load strobe for register_16
//   pc_out                      : current PC
//   busy                        : high whenever the FSM is not idle
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int                DATA_W   = DEFAULT_DATA_W,
    parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [DATA_W-1:0] branch_target,
    output logic              mem_req,
    output logic [DATA_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ir_in,
    output logic              ir_load,
    output logic [DATA_W-1:0] pc_out,
    output logic              busy
);

    state_t            state;
    state_t            state_next;
    logic              squash;
    logic              kill;
    logic              req_open;
    logic [DATA_W-1:0] req_addr;
    logic [DATA_W-1:0] ir_word;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] pc_next;

    // A request is killed if it was redirected earlier, or if the redirect
    // arrives in the same cycle as its ack.
    assign kill = squash | branch_taken;

    // The outstanding request keeps its address until acked; otherwise the
    // latch follows the PC so a new request always starts at the current pc.
    assign req_open = (state == ST_FETCH) && !mem_ack;

    fetch_sequencer_pc_counter #(
        .DATA_W   (DATA_W),
        .RESET_PC (RESET_PC)
    ) u_pc_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (branch_taken),
        .load_value (branch_target),
        .incr       (state == ST_LOAD),
        .count      (pc),
        .count_next (pc_next)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (run) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem_ack && !kill) state_next = ST_LOAD;
            end
            ST_LOAD, ST_HOLD: begin
                if (stall)    state_next = ST_HOLD;
                else if (run) state_next = ST_FETCH;
                else          state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        mem_req = (state == ST_FETCH);
        ir_load = (state == ST_LOAD);
        busy    = (state != ST_IDLE);
    end

    assign mem_addr = req_addr;
    assign ir_in    = ir_word;
    assign pc_out   = pc;

    // Squash flag, request-address latch and fetched word
    always_ff @(posedge clk) begin
        if (reset) begin
            squash   <= 1'b0;
            req_addr <= RESET_PC;
            ir_word  <= '0;
        end else begin
            // Only an ack retires a squashed request; a branch with no ack
            // marks the still-pending request as stale.
            if (state == ST_FETCH) begin
                if (mem_ack) begin
                    squash <= 1'b0;
                end else if (branch_taken) begin
                    squash <= 1'b1;
                end
            end
            if ((state == ST_FETCH) && mem_ack && !kill) begin
                ir_word <= mem_rdata;
            end
            if (!req_open) begin
                req_addr <= pc_next;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] ir_in;
    logic        ir_load;
    logic [15:0] pc_out;
    logic        busy;

    fetch_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .run           (run),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .ir_in         (ir_in),
        .ir_load       (ir_load),
        .pc_out        (pc_out),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, and settle past the edge.
    task automatic apply(input logic r, input logic rn, input logic st, input logic br,
                         input logic [15:0] tgt, input logic ack, input logic [15:0] rdata);
        reset         = r;
        run           = rn;
        stall         = st;
        branch_taken  = br;
        branch_target = tgt;
        mem_ack       = ack;
        mem_rdata     = rdata;
        @(posedge clk);
        #1;
    endtask

    // Packed view of the outputs; the address only matters while requesting.
    function automatic logic [63:0] pack(input logic req, input logic [15:0] addr, input logic ld,
                                         input logic [15:0] ir, input logic [15:0] pc, input logic bsy);
        return {12'h0, req, (req ? addr : 16'h0), ld, ir, pc, bsy};
    endfunction

    typedef struct {
        logic        r, rn, st, br;
        logic [15:0] tgt;
        logic        ack;
        logic [15:0] rdata;
        logic        req;
        logic [15:0] addr;
        logic        ld;
        logic [15:0] ir;
        logic [15:0] pc;
        logic        bsy;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic rn, input logic st, input logic br,
                                input logic [15:0] tgt, input logic ack, input logic [15:0] rdata,
                                input logic req, input logic [15:0] addr, input logic ld,
                                input logic [15:0] ir, input logic [15:0] pc, input logic bsy);
        vec_t v;
        v.r = r; v.rn = rn; v.st = st; v.br = br; v.tgt = tgt; v.ack = ack; v.rdata = rdata;
        v.req = req; v.addr = addr; v.ld = ld; v.ir = ir; v.pc = pc; v.bsy = bsy;
        return v;
    endfunction

    // Transaction-level reference: what the fetch unit is doing right now.
    bit          m_fetching, m_kill, m_loading, m_holding;
    logic [15:0] m_pc, m_addr, m_word;

    task automatic model_step(input logic r, input logic rn, input logic st, input logic br,
                              input logic [15:0] tgt, input logic ack, input logic [15:0] rdata);
        logic [15:0] new_pc;
        if (r) begin
            m_fetching = 0; m_kill = 0; m_loading = 0; m_holding = 0;
            m_pc = 16'h0000; m_word = 16'h0000; m_addr = 16'h0000;
        end else begin
            new_pc = br ? tgt : (m_loading ? 16'(m_pc + 16'd1) : m_pc);
            if (m_fetching) begin
                if (ack) begin
                    if (m_kill || br) begin
                        m_addr = new_pc;
                        m_kill = 0;
                    end else begin
                        m_fetching = 0;
                        m_loading  = 1;
                        m_word     = rdata;
                    end
                end else if (br) begin
                    m_kill = 1;
                end
            end else if (m_loading) begin
                m_loading = 0;
                if (st) m_holding = 1;
                else if (rn) begin m_fetching = 1; m_addr = new_pc; end
            end else if (m_holding) begin
                if (!st) begin
                    m_holding = 0;
                    if (rn) begin m_fetching = 1; m_addr = new_pc; end
                end
            end else if (rn) begin
                m_fetching = 1;
                m_addr = new_pc;
            end
            m_pc = new_pc;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[$];
        int   loads;

        reset = 1'b1; run = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        branch_target = 16'h0; mem_ack = 1'b0; mem_rdata = 16'h0;

        //                r  rn st br tgt       ack rdata      req addr      ld ir        pc        busy
        // Reset state and zero-wait fetches of 0,1,2 (data = addr ^ A5A5)
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 16'h0000,  0, 16'h0000, 0, 16'h0000, 16'h0000, 0));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 16'h0000,  1, 16'h0000, 0, 16'h0000, 16'h0000, 1));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 1, 16'hA5A5,  0, 16'h0000, 1, 16'hA5A5, 16'h0000, 1));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 16'h0000,  1, 16'h0001, 0, 16'hA5A5, 16'h0001, 1));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 1, 16'hA5A4,  0, 16'h0000, 1, 16'hA5A4, 16'h0001, 1));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 16'h0000,  1, 16'h0002, 0, 16'hA5A4, 16'h0002, 1));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 1, 16'hA5A7,  0, 16'h0000, 1, 16'hA5A7, 16'h0002, 1));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 16'h0000,  0, 16'h0000, 0, 16'hA5A7, 16'h0003, 0));
        // Wrap: branch to FFFF in IDLE, fetch it, next request at 0000; run drops mid-fetch
        vecs.push_back(mk(0, 0, 0, 1, 16'hFFFF, 0, 16'h0000,  0, 16'h0000, 0, 16'hA5A7, 16'hFFFF, 0));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 16'h0000,  1, 16'hFFFF, 0, 16'hA5A7, 16'hFFFF, 1));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 1, 16'h1234,  0, 16'h0000, 1, 16'h1234, 16'hFFFF, 1));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 16'h0000,  1, 16'h0000, 0, 16'h1234, 16'h0000, 1));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 16'hA5A5,  0, 16'h0000, 1, 16'hA5A5, 16'h0000, 1));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 16'h0000,  0, 16'h0000, 0, 16'hA5A5, 16'h0001, 0));
        // Branch to 0040 while fetch of 0005 is pending: squashed ack, refetch at 0040
        vecs.push_back(mk(0, 0, 0, 1, 16'h0005, 0, 16'h0000,  0, 16'h0000, 0, 16'hA5A5, 16'h0005, 0));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 16'h0000,  1, 16'h0005, 0, 16'hA5A5, 16'h0005, 1));
        vecs.push_back(mk(0, 1, 0, 1, 16'h0040, 0, 16'h0000,  1, 16'h0005, 0, 16'hA5A5, 16'h0040, 1));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 1, 16'hBEEF,  1, 16'h0040, 0, 16'hA5A5, 16'h0040, 1));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 1, 16'hA5E5,  0, 16'h0000, 1, 16'hA5E5, 16'h0040, 1));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 16'h0000,  0, 16'h0000, 0, 16'hA5E5, 16'h0041, 0));
        // Stall asserted in LOAD for 5 cycles, fetch of pc+1 right after it falls
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 16'h0000,  1, 16'h0041, 0, 16'hA5E5, 16'h0041, 1));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 1, 16'h1111,  0, 16'h0000, 1, 16'h1111, 16'h0041, 1));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 1, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h1111, 16'h0042, 1));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 16'h0000,  1, 16'h0042, 0, 16'h1111, 16'h0042, 1));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 1, 16'h2222,  0, 16'h0000, 1, 16'h2222, 16'h0042, 1));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 16'h0000,  0, 16'h0000, 0, 16'h2222, 16'h0043, 0));
        // Three wait states: request at 0000 held for 4 cycles, one load
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 16'h0000,  0, 16'h0000, 0, 16'h0000, 16'h0000, 0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'h0000, 1));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 1, 16'h5A5A,  0, 16'h0000, 1, 16'h5A5A, 16'h0000, 1));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 16'h0000,  0, 16'h0000, 0, 16'h5A5A, 16'h0001, 0));
        // Reset mid-fetch, late ack ignored
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 16'h0000,  1, 16'h0001, 0, 16'h5A5A, 16'h0001, 1));
        vecs.push_back(mk(1, 1, 0, 0, 16'h0000, 0, 16'h0000,  0, 16'h0000, 0, 16'h0000, 16'h0000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 16'h9999,  0, 16'h0000, 0, 16'h0000, 16'h0000, 0));
        // Branch in LOAD overrides the increment; the word still loads
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 16'h0000,  1, 16'h0000, 0, 16'h0000, 16'h0000, 1));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 1, 16'h7777,  0, 16'h0000, 1, 16'h7777, 16'h0000, 1));
        vecs.push_back(mk(0, 1, 0, 1, 16'h0100, 0, 16'h0000,  1, 16'h0100, 0, 16'h7777, 16'h0100, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].r, vecs[i].rn, vecs[i].st, vecs[i].br, vecs[i].tgt, vecs[i].ack, vecs[i].rdata);
            check($sformatf("vec[%0d]", i), pack(mem_req, mem_addr, ir_load, ir_in, pc_out, busy),
                  pack(vecs[i].req, vecs[i].addr, vecs[i].ld, vecs[i].ir, vecs[i].pc, vecs[i].bsy));
        end

        // Zero-wait throughput: always-acking memory, one word every 2 cycles
        apply(1, 0, 0, 0, 16'h0, 0, 16'h0);
        loads = 0;
        for (int c = 0; c < 20; c++) begin
            apply(0, 1, 0, 0, 16'h0, 1, mem_addr ^ 16'hA5A5);
            if (ir_load) begin
                check("zw_word", ir_in, 16'(loads) ^ 16'hA5A5);
                check("zw_pc", pc_out, 16'(loads));
                loads++;
            end
        end
        check("zw_rate", loads, 10);

        // Randomized run against the reference
        apply(1, 0, 0, 0, 16'h0, 0, 16'h0);
        model_step(1, 0, 0, 0, 16'h0, 0, 16'h0);
        for (int c = 0; c < 3000; c++) begin
            logic        r, rn, st, br, ack;
            logic [15:0] tgt, rdata;
            r     = ($urandom_range(0, 99) == 0);
            rn    = ($urandom_range(0, 9) != 0);
            st    = ($urandom_range(0, 4) == 0);
            br    = ($urandom_range(0, 11) == 0);
            tgt   = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            ack   = ($urandom_range(0, 2) == 0);
            rdata = 16'($urandom);
            model_step(r, rn, st, br, tgt, ack, rdata);
            apply(r, rn, st, br, tgt, ack, rdata);
            check($sformatf("rand[%0d]", c), pack(mem_req, mem_addr, ir_load, ir_in, pc_out, busy),
                  pack(m_fetching, m_addr, m_loading, m_word, m_pc,
                       m_fetching | m_loading | m_holding));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Multi-cycle instruction fetch stage sitting directly upstream of the 16-bit instruction register (register_16).
- Owns the program counter (PC) and issues word reads to instruction memory over a req/ack handshake.
- Presents the fetched word on ir_in and pulses ir_load for exactly one cycle so register_16 captures it.
- Handles stall, branch redirect, and squashing of a fetch that is in flight.

Parameters:
- DATA_W, 16, width of the instruction word, the PC and the memory address.
- RESET_PC, 16'h0000, PC value after reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  level; enables fetching.
- stall  in  1  level; freezes issue of the next fetch.
- branch_taken  in  1  single-cycle redirect strobe.
- branch_target  in  DATA_W  redirect address, valid while branch_taken=1.
- mem_req  out  1  read request to instruction memory.
- mem_addr  out  DATA_W  read address; equals pc while mem_req=1.
- mem_ack  in  1  memory returns data this cycle.
- mem_rdata  in  DATA_W  read data, valid while mem_ack=1.
- ir_in  out  DATA_W  word for register_16 "in".
- ir_load  out  1  one-cycle load strobe for register_16 "load".
- pc_out  out  DATA_W  current PC.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset values (a clock edge with reset=1, taking priority over all other inputs): state=IDLE, pc=RESET_PC, ir_in=0, ir_load=0, mem_req=0, squash=0, busy=0.
- States are IDLE, FETCH, LOAD, HOLD. mem_req=1 only in FETCH. ir_load=1 only in LOAD.
- IDLE:
  - run=1 -> FETCH.
  - Otherwise stay in IDLE.
- FETCH:
  - mem_req=1, mem_addr=pc; hold both stable until mem_ack=1 is sampled.
  - On mem_ack with squash=0: ir_in<=mem_rdata, then -> LOAD.
  - On mem_ack with squash=1: discard the data, clear squash, stay in FETCH (new request issued at the redirected pc on the next cycle).
- LOAD:
  - ir_load=1 for exactly one cycle; ir_in is stable and register_16 captures it on this edge.
  - pc<=pc+1, wrapping 16'hFFFF -> 16'h0000.
  - Next state: stall=1 -> HOLD; else run=1 -> FETCH; else IDLE.
- HOLD:
  - Stay while stall=1.
  - When stall=0: -> FETCH if run=1, else IDLE.
- branch_taken:
  - In IDLE/HOLD: pc<=branch_target.
  - In LOAD: pc<=branch_target, overriding the increment. ir_load is still asserted for the word already fetched; the consumer squashes it.
  - In FETCH: pc<=branch_target and squash<=1. The outstanding request stays asserted until its ack, with the address held at the old value.
  - squash is cleared by the squashed ack or by reset.
- mem_addr is driven from a latched request address, so a redirect during FETCH does not change it mid-request.
- mem_ack outside FETCH is ignored.
- Latency: for a zero-wait memory (ack in the first FETCH cycle), one instruction every 2 cycles. Each memory wait cycle adds 1.
- run deasserted during FETCH: the fetch completes and loads, then the block goes to IDLE.
- stall during FETCH has no effect until LOAD is reached.
- Reset mid-FETCH: mem_req drops in the cycle after the reset edge. A late ack is ignored.

Decomposition:
- Shared package holds:
  - The state encoding (IDLE=2'b00, FETCH=2'b01, LOAD=2'b10, HOLD=2'b11).
  - The DATA_W and RESET_PC defaults.
- One sub-module, pc_counter: a 16-bit register with load (branch target), increment with wrap, and synchronous reset to RESET_PC.
- The FSM, the squash flag, the request-address latch and ir_in live in fetch_sequencer.

Test Plan:
- Zero-wait memory: reset, run=1, memory returns mem_rdata=addr^16'hA5A5 with an immediate ack -> ir_load pulses every 2nd cycle with ir_in=16'hA5A5,16'hA5A4,...; pc_out goes 0,1,2.
- Wait states: ack delayed 3 cycles -> mem_req and mem_addr=16'h0000 held for 4 cycles; a single ir_load; pc becomes 1.
- Wrap-around: branch to 16'hFFFF, then fetch -> mem_addr=16'hFFFF, then pc=16'h0000, and the next mem_addr=16'h0000.
- Branch in FETCH: branch_target=16'h0040 strobed during a pending fetch of 16'h0005 -> ack for 0005 produces no ir_load; the next request is at 16'h0040; ir_load follows with that word.
- Stall: stall=1 asserted during LOAD for 5 cycles -> state HOLD, mem_req=0 throughout; the fetch of pc+1 starts in the cycle after stall falls.
- Reset mid-fetch: reset during FETCH with ack arriving 1 cycle later -> mem_req=0, ir_load stays 0, pc=RESET_PC, busy=0.
